// File: rtl/uart_alu_ctrl_pkg.sv
// Shared definitions for the UART/ALU frame sequencer: opcode values,
// defaults and the FSM state encoding.
package uart_alu_ctrl_pkg;

  localparam int          NB_OP_DEF    = 6;
  localparam logic [7:0]  ERR_CODE_DEF = 8'hFF;

  localparam logic [5:0] OP_ADD = 6'h20;
  localparam logic [5:0] OP_SUB = 6'h22;
  localparam logic [5:0] OP_AND = 6'h24;
  localparam logic [5:0] OP_OR  = 6'h25;
  localparam logic [5:0] OP_XOR = 6'h26;
  localparam logic [5:0] OP_NOR = 6'h27;
  localparam logic [5:0] OP_SRA = 6'h03;
  localparam logic [5:0] OP_SRL = 6'h02;

  localparam int NUM_OPS = 8;
  localparam logic [5:0] VALID_OPS [NUM_OPS] = '{
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL
  };

  typedef enum logic [2:0] {
    ST_GET_A  = 3'd0,
    ST_GET_B  = 3'd1,
    ST_GET_OP = 3'd2,
    ST_EXEC   = 3'd3,
    ST_SEND   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_alu_ctrl_alu_op_check.sv
// Combinational opcode validator: flags whether an opcode belongs to the
// set of operations the ALU implements.
module alu_op_check
  import uart_alu_ctrl_pkg::*;
#(
  parameter int NB_OP = NB_OP_DEF
) (
  input  logic [NB_OP-1:0] i_op,
  output logic             o_valid
);

  logic [NUM_OPS-1:0] match;

  generate
    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_match
      assign match[gi] = (i_op == NB_OP'(VALID_OPS[gi]));
    end
  endgenerate

  assign o_valid = |match;

endmodule

// File: rtl/uart_alu_ctrl.sv
// Frame sequencer: pops A, B and opcode bytes from the RX FIFO, drives the
// ALU registers, and pushes one result (or error code) byte to the TX FIFO.
module uart_alu_ctrl
  import uart_alu_ctrl_pkg::*;
#(
  parameter int                 NB_DATA    = 8,
  parameter int                 NB_OP      = NB_OP_DEF,
  parameter int                 NB_TIMEOUT = 24,
  parameter int                 TIMEOUT    = 10000000,
  parameter logic [NB_DATA-1:0] ERR_CODE   = NB_DATA'(ERR_CODE_DEF)
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_empty,
  output logic               o_rx_rd,
  input  logic               i_tx_full,
  output logic               o_tx_wr,
  output logic [NB_DATA-1:0] o_tx_wdata,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  output logic               o_err,
  output logic               o_timeout
);

  localparam logic [NB_TIMEOUT-1:0] TMO_LAST = NB_TIMEOUT'(TIMEOUT - 1);

  state_t                state_reg, state_next;
  logic [NB_TIMEOUT-1:0] tmo_cnt_reg;
  logic                  err_flag_reg;
  logic                  op_valid;
  logic                  in_get;
  logic                  in_wait;
  logic                  tmo_hit;

  alu_op_check #(.NB_OP(NB_OP)) u_op_check (
    .i_op    (i_rx_data[NB_OP-1:0]),
    .o_valid (op_valid)
  );

  assign in_get  = (state_reg == ST_GET_A) || (state_reg == ST_GET_B) ||
                   (state_reg == ST_GET_OP);
  assign in_wait = (state_reg == ST_GET_B) || (state_reg == ST_GET_OP);
  // A pop in the same cycle always beats the timeout.
  assign tmo_hit = in_wait && !o_rx_rd && (tmo_cnt_reg == TMO_LAST);

  always_ff @(posedge clk) begin
    if (i_rst) state_reg <= ST_GET_A;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_GET_A:  if (o_rx_rd) state_next = ST_GET_B;
      ST_GET_B:  if (o_rx_rd) state_next = ST_GET_OP;
                 else if (tmo_hit) state_next = ST_GET_A;
      ST_GET_OP: if (o_rx_rd) state_next = ST_EXEC;
                 else if (tmo_hit) state_next = ST_GET_A;
      ST_EXEC:   state_next = ST_SEND;
      ST_SEND:   if (!i_tx_full) state_next = ST_GET_A;
      default:   state_next = ST_GET_A;
    endcase
  end

  always_comb begin
    o_rx_rd = in_get && !i_rx_empty;
    o_tx_wr = (state_reg == ST_SEND) && !i_tx_full;
  end

  // Saturating inter-byte counter; only runs while a frame is half received.
  always_ff @(posedge clk) begin
    if (i_rst || !in_wait || o_rx_rd || tmo_hit) tmo_cnt_reg <= '0;
    else if (tmo_cnt_reg != TMO_LAST)             tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_alu_a      <= '0;
      o_alu_b      <= '0;
      o_alu_op     <= '0;
      o_tx_wdata   <= '0;
      o_err        <= 1'b0;
      o_timeout    <= 1'b0;
      err_flag_reg <= 1'b0;
    end else begin
      o_err     <= 1'b0;
      o_timeout <= tmo_hit;
      case (state_reg)
        ST_GET_A: if (o_rx_rd) o_alu_a <= i_rx_data;
        ST_GET_B: if (o_rx_rd) o_alu_b <= i_rx_data;
        ST_GET_OP: begin
          if (o_rx_rd) begin
            if (op_valid) begin
              o_alu_op     <= i_rx_data[NB_OP-1:0];
              err_flag_reg <= 1'b0;
            end else begin
              err_flag_reg <= 1'b1;
              o_err        <= 1'b1;
            end
          end
        end
        ST_EXEC: o_tx_wdata <= err_flag_reg ? ERR_CODE : i_alu_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Bench for uart_alu_ctrl: queue-based RX FIFO, behavioural ALU and a
// frame-level scoreboard of expected TX bytes.
module tb_uart_alu_ctrl;

  localparam int TMO = 1000;

  logic       clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_rx_data;
  logic       i_rx_empty;
  logic       o_rx_rd;
  logic       i_tx_full;
  logic       o_tx_wr;
  logic [7:0] o_tx_wdata;
  logic [7:0] o_alu_a;
  logic [7:0] o_alu_b;
  logic [5:0] o_alu_op;
  logic [7:0] i_alu_result;
  logic       o_err;
  logic       o_timeout;

  always #5 clk = ~clk;

  uart_alu_ctrl #(
    .NB_DATA(8), .NB_OP(6), .NB_TIMEOUT(24), .TIMEOUT(TMO), .ERR_CODE(8'hFF)
  ) dut (
    .clk(clk), .i_rst(i_rst),
    .i_rx_data(i_rx_data), .i_rx_empty(i_rx_empty), .o_rx_rd(o_rx_rd),
    .i_tx_full(i_tx_full), .o_tx_wr(o_tx_wr), .o_tx_wdata(o_tx_wdata),
    .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
    .i_alu_result(i_alu_result), .o_err(o_err), .o_timeout(o_timeout)
  );

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return 8'($signed(a) >>> b);
      6'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit op_ok(input logic [7:0] op_byte);
    logic [5:0] op;
    op = op_byte[5:0];
    return op inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};
  endfunction

  always_comb i_alu_result = alu_f(o_alu_a, o_alu_b, o_alu_op);

  int total = 0;
  int bad   = 0;

  logic [7:0] rxq[$];
  logic [7:0] exp_q[$];
  logic [5:0] exp_op;
  logic [7:0] push_q[$];
  int         push_cyc[$];
  int         pop_cyc[$];
  int         cyc = 0;
  int         err_cnt, err_last, tmo_cnt, tmo_last, viol;
  bit         gap_en, rnd_full, force_full;

  // One clock of stimulus plus observation of the combinational strobes.
  task automatic cycle();
    @(negedge clk);
    i_rx_empty = (rxq.size() == 0) || (gap_en && $urandom_range(0, 3) == 0);
    i_rx_data  = (rxq.size() != 0) ? rxq[0] : 8'($urandom);
    i_tx_full  = force_full || (rnd_full && $urandom_range(0, 2) == 0);
    #1;
    if (o_rx_rd && i_rx_empty) viol++;
    if (o_tx_wr && i_tx_full)  viol++;
    if (o_rx_rd) begin
      void'(rxq.pop_front());
      pop_cyc.push_back(cyc);
    end
    if (o_tx_wr) begin
      push_q.push_back(o_tx_wdata);
      push_cyc.push_back(cyc);
    end
    if (o_err)     begin err_cnt++; err_last = cyc; end
    if (o_timeout) begin tmo_cnt++; tmo_last = cyc; end
    cyc++;
  endtask

  task automatic clear_log();
    push_q.delete(); push_cyc.delete(); pop_cyc.delete(); exp_q.delete();
    err_cnt = 0; err_last = -1; tmo_cnt = 0; tmo_last = -1;
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] op);
    rxq.push_back(a); rxq.push_back(b); rxq.push_back(op);
    if (op_ok(op)) begin
      exp_q.push_back(alu_f(a, b, op[5:0]));
      exp_op = op[5:0];
    end else begin
      exp_q.push_back(8'hFF);
    end
  endtask

  task automatic drain(input int max, output bit ok);
    int n = 0;
    while ((push_q.size() < exp_q.size() || rxq.size() != 0) && n < max) begin
      cycle();
      n++;
    end
    ok = (n < max);
    repeat (4) cycle();
  endtask

  task automatic wait_pops(input int cnt, output bit ok);
    int n = 0;
    while (pop_cyc.size() < cnt && n < 200) begin
      cycle();
      n++;
    end
    ok = (n < 200);
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) cycle();
    total++; if (o_alu_a !== 8'h00) begin bad++; $display("FAIL reset_a: got %0h want 0", o_alu_a); end
    total++; if (o_alu_b !== 8'h00) begin bad++; $display("FAIL reset_b: got %0h want 0", o_alu_b); end
    total++; if (o_alu_op !== 6'h00) begin bad++; $display("FAIL reset_op: got %0h want 0", o_alu_op); end
    total++; if (o_tx_wdata !== 8'h00) begin bad++; $display("FAIL reset_wdata: got %0h want 0", o_tx_wdata); end
    total++; if ({o_err, o_timeout, o_tx_wr} !== 3'b000) begin
      bad++; $display("FAIL reset_pulses: got %b want 000", {o_err, o_timeout, o_tx_wr});
    end
    i_rst = 1'b0;
    exp_op = 6'h00;
    cycle();
    $display("reset: checked");
  endtask

  task automatic test_basic();
    bit ok;
    clear_log();
    send_frame(8'h05, 8'h03, 8'h20);
    drain(100, ok);
    total++; if (!ok || push_q.size() != 1) begin bad++; $display("FAIL basic_count: got %0d want 1", push_q.size()); end
    else begin
      total++; if (push_q[0] !== 8'h08) begin bad++; $display("FAIL basic_data: got %0h want 08", push_q[0]); end
      total++; if (push_cyc[0] - pop_cyc[2] != 2) begin
        bad++; $display("FAIL basic_latency: got %0d want 2", push_cyc[0] - pop_cyc[2]);
      end
    end
    total++; if (o_alu_op !== 6'h20) begin bad++; $display("FAIL basic_op: got %0h want 20", o_alu_op); end
    $display("basic: 05,03,20 -> %0d push(es)", push_q.size());
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_log();
    send_frame(8'h03, 8'h05, 8'h22);
    send_frame(8'hF0, 8'h0F, 8'h25);
    drain(100, ok);
    total++; if (!ok || push_q.size() != 2 || pop_cyc.size() != 6) begin
      bad++; $display("FAIL b2b_count: got %0d want 2", push_q.size());
    end else begin
      total++; if (push_q[0] !== 8'hFE) begin bad++; $display("FAIL b2b_first: got %0h want fe", push_q[0]); end
      total++; if (push_q[1] !== 8'hFF) begin bad++; $display("FAIL b2b_second: got %0h want ff", push_q[1]); end
      total++; if (pop_cyc[3] != push_cyc[0] + 1) begin
        bad++; $display("FAIL b2b_next_pop: got %0d want %0d", pop_cyc[3], push_cyc[0] + 1);
      end
    end
    $display("back_to_back: 2 frames, %0d push(es)", push_q.size());
  endtask

  task automatic test_invalid();
    bit ok;
    clear_log();
    send_frame(8'h12, 8'h34, 8'h3F);
    drain(100, ok);
    total++; if (err_cnt != 1) begin bad++; $display("FAIL inv_err_count: got %0d want 1", err_cnt); end
    total++; if (!ok || push_q.size() != 1 || pop_cyc.size() != 3) begin
      bad++; $display("FAIL inv_count: got %0d want 1", push_q.size());
    end else begin
      total++; if (err_last != pop_cyc[2] + 1) begin
        bad++; $display("FAIL inv_err_time: got %0d want %0d", err_last, pop_cyc[2] + 1);
      end
      total++; if (push_q[0] !== 8'hFF) begin bad++; $display("FAIL inv_data: got %0h want ff", push_q[0]); end
    end
    total++; if (o_alu_op !== exp_op) begin bad++; $display("FAIL inv_op_hold: got %0h want %0h", o_alu_op, exp_op); end
    $display("invalid: 12,34,3F -> err pulses %0d", err_cnt);
  endtask

  task automatic test_tx_full();
    bit ok;
    int unstable = 0;
    int rel;
    logic [7:0] w0;
    clear_log();
    force_full = 1'b1;
    send_frame(8'h5A, 8'h0F, 8'h24);
    wait_pops(3, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_pops: got %0d want 3", pop_cyc.size()); end
    cycle();
    cycle();
    w0 = o_tx_wdata;
    repeat (9) begin
      cycle();
      if (o_tx_wdata !== w0) unstable++;
    end
    total++; if (push_q.size() != 0) begin bad++; $display("FAIL full_no_push: got %0d want 0", push_q.size()); end
    total++; if (unstable != 0) begin bad++; $display("FAIL full_stable: got %0d changes want 0", unstable); end
    total++; if (w0 !== exp_q[0]) begin bad++; $display("FAIL full_data: got %0h want %0h", w0, exp_q[0]); end
    force_full = 1'b0;
    rel = cyc;
    repeat (4) cycle();
    total++; if (push_q.size() != 1 || push_cyc[0] != rel) begin
      bad++; $display("FAIL full_release: got %0d push(es) want 1 at cycle %0d", push_q.size(), rel);
    end
    $display("tx_full: held 10 cycles, %0d push(es) after release", push_q.size());
  endtask

  task automatic test_timeout();
    bit ok;
    int a_cyc;
    clear_log();
    rxq.push_back(8'h07);
    wait_pops(1, ok);
    a_cyc = pop_cyc[0];
    repeat (TMO + 5) cycle();
    total++; if (tmo_cnt != 1) begin bad++; $display("FAIL tmo_count: got %0d want 1", tmo_cnt); end
    total++; if (tmo_last != a_cyc + TMO + 1) begin
      bad++; $display("FAIL tmo_time: got %0d want %0d", tmo_last, a_cyc + TMO + 1);
    end
    total++; if (push_q.size() != 0) begin bad++; $display("FAIL tmo_no_push: got %0d want 0", push_q.size()); end
    total++; if (o_alu_a !== 8'h07) begin bad++; $display("FAIL tmo_keep_a: got %0h want 07", o_alu_a); end
    clear_log();
    send_frame(8'h01, 8'h02, 8'h20);
    drain(100, ok);
    total++; if (!ok || push_q.size() != 1 || push_q[0] !== 8'h03) begin
      bad++; $display("FAIL tmo_recover: got %0d push(es) want one 03", push_q.size());
    end
    // A byte arriving on the very last allowed cycle must still be taken.
    clear_log();
    rxq.push_back(8'h04);
    wait_pops(1, ok);
    repeat (TMO - 1) cycle();
    rxq.push_back(8'h06); rxq.push_back(8'h26);
    exp_q.push_back(8'h02); exp_op = 6'h26;
    drain(100, ok);
    total++; if (tmo_cnt != 0) begin bad++; $display("FAIL tmo_pop_wins: got %0d timeouts want 0", tmo_cnt); end
    total++; if (!ok || push_q.size() != 1 || push_q[0] !== 8'h02) begin
      bad++; $display("FAIL tmo_edge_frame: got %0d push(es) want one 02", push_q.size());
    end
    $display("timeout: pulse at +%0d, edge frame push(es) %0d", TMO + 1, push_q.size());
  endtask

  task automatic test_rst_mid();
    bit ok;
    clear_log();
    rxq.push_back(8'h09); rxq.push_back(8'h01);
    wait_pops(2, ok);
    i_rst = 1'b1;
    cycle();
    i_rst = 1'b0;
    cycle();
    exp_op = 6'h00;
    total++; if ({o_alu_a, o_alu_b, o_tx_wdata} !== 24'h0 || o_alu_op !== 6'h0 || {o_err, o_timeout} !== 2'b00) begin
      bad++; $display("FAIL rst_mid_regs: got a=%0h b=%0h op=%0h w=%0h want all 0", o_alu_a, o_alu_b, o_alu_op, o_tx_wdata);
    end
    send_frame(8'h09, 8'h01, 8'h22);
    drain(100, ok);
    total++; if (!ok || push_q.size() != 1 || push_q[0] !== 8'h08) begin
      bad++; $display("FAIL rst_mid_frame: got %0d push(es) want one 08", push_q.size());
    end
    $display("rst_mid: partial frame dropped, next frame push(es) %0d", push_q.size());
  endtask

  task automatic test_random();
    bit ok;
    int mism = 0;
    logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h03, 8'h02};
    logic [7:0] op;
    clear_log();
    gap_en = 1'b1;
    rnd_full = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) op = 8'($urandom);
      else op = ops[$urandom_range(0, 7)] | {$urandom_range(0, 3), 6'h00};
      send_frame(8'($urandom), 8'($urandom), op);
    end
    drain(4000, ok);
    gap_en = 1'b0;
    rnd_full = 1'b0;
    total++; if (!ok || push_q.size() != exp_q.size()) begin
      bad++; $display("FAIL rand_count: got %0d want %0d", push_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) if (push_q[i] !== exp_q[i]) mism++;
      total++; if (mism != 0) begin bad++; $display("FAIL rand_data: got %0d mismatching bytes want 0", mism); end
    end
    total++; if (o_alu_op !== exp_op) begin bad++; $display("FAIL rand_op: got %0h want %0h", o_alu_op, exp_op); end
    total++; if (viol != 0) begin bad++; $display("FAIL protocol: got %0d strobe violations want 0", viol); end
    $display("random: 40 frames, %0d push(es)", push_q.size());
  endtask

  initial begin
    i_rst = 1'b1; i_rx_empty = 1'b1; i_rx_data = 8'h00; i_tx_full = 1'b0;
    gap_en = 1'b0; rnd_full = 1'b0; force_full = 1'b0; viol = 0;
    clear_log();
    test_reset();
    test_basic();
    test_back_to_back();
    test_invalid();
    test_tx_full();
    test_timeout();
    test_rst_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
